sram_mem_controller: RTL and testbench

Sequences each MEM-stage load/store in the ARM pipeline onto the 16-bit external SRAM as two halfword accesses. It sits between the EX/MEM pipeline register outputs and the SRAM pins. While an access is in flight it drives `freeze` so that every pipeline register holds. `ready` returns the pipeline to normal flow for exactly one cycle when the 32-bit word is complete.

---
 rtl/sram_ctrl_pkg.sv | 32 +++
 rtl/sram_mem_controller_if.sv | 40 ++++
 rtl/sram_wait_counter.sv | 35 +++
 rtl/sram_mem_controller.sv | 171 +++++++++++++++++
 tb/tb_sram_mem_controller.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
// Shared definitions for the SRAM memory controller slice.
//   state_t           : controller state encodings (six states)
//   SRAM_AW / SRAM_DW : external SRAM halfword-address and data widths
//   WORD_AW           : width of a 32-bit word index (one halfword address bit less)
//   DEFAULT_*         : default access wait length and address offset
//   halfword_addr()   : builds the SRAM halfword address from a word index and half select
package sram_ctrl_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    localparam int WORD_AW = SRAM_AW - 1;

    localparam int DEFAULT_WAIT_CYCLES = 3;
    localparam int DEFAULT_ADDR_OFFSET = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_WR_LO = 3'd3,
        ST_WR_HI = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Low halfword of a word lives at {w,0}, high halfword at {w,1}.
    function automatic logic [SRAM_AW-1:0] halfword_addr(input logic [WORD_AW-1:0] word,
                                                         input logic hi);
        return {word, hi};
    endfunction

endpackage

// File: rtl/sram_mem_controller_if.sv
// sram_mem_controller_if
// Pipeline-side bus between the EX/MEM register and the SRAM controller.
//   mem_r_en, mem_w_en : load / store request
//   addr               : byte address (ALU result)
//   wdata              : store data
//   rdata              : assembled load word
//   ready              : access complete or nothing requested
//   freeze             : inverse of ready, holds every pipeline register
// Modports: master = pipeline side, slave = controller side.
interface sram_mem_controller_if;

    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        freeze;

    modport master (
        output mem_r_en,
        output mem_w_en,
        output addr,
        output wdata,
        input  rdata,
        input  ready,
        input  freeze
    );

    modport slave (
        input  mem_r_en,
        input  mem_w_en,
        input  addr,
        input  wdata,
        output rdata,
        output ready,
        output freeze
    );

endinterface

// File: rtl/sram_wait_counter.sv
// sram_wait_counter
// Loadable down-counter that times each halfword access state.
//   clk   : clock
//   rst   : synchronous active-high reset (count to 0)
//   start : load WAIT_CYCLES-1; asserted on the cycle before an access state begins
//   last  : high on the final cycle of the current access state
// The count idles at zero, so with WAIT_CYCLES = 1 every access cycle is a last cycle.
module sram_wait_counter
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic last
);

    localparam logic [3:0] LOAD_VAL = 4'(WAIT_CYCLES - 1);

    logic [3:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= 4'd0;
        end else if (start) begin
            count_reg <= LOAD_VAL;
        end else if (count_reg != 4'd0) begin
            count_reg <= count_reg - 4'd1;
        end
    end

    assign last = (count_reg == 4'd0);

endmodule

// File: rtl/sram_mem_controller.sv
// sram_mem_controller
// Turns each MEM-stage 32-bit load/store into two halfword accesses on a
// 16-bit external SRAM, freezing the pipeline while the access is in flight.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : pipeline request/response (mem_r_en, mem_w_en, addr,
//                     wdata, rdata, ready, freeze)
//   sram_addr       : halfword address to the SRAM
//   sram_we_n       : active-low write strobe
//   sram_dq_out     : write data to the SRAM
//   sram_dq_oe      : data bus drive enable (tristate built above this level)
//   sram_dq_in      : read data from the SRAM
// Optional feature: define SRAM_READ_HIT_EN to add a one-entry buffer that
// remembers the last completed read word so a repeated load finishes at once.
module sram_mem_controller
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int ADDR_OFFSET = DEFAULT_ADDR_OFFSET
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_mem_controller_if.slave  bus,
    output logic [SRAM_AW-1:0]    sram_addr,
    output logic                  sram_we_n,
    output logic [SRAM_DW-1:0]    sram_dq_out,
    output logic                  sram_dq_oe,
    input  logic [SRAM_DW-1:0]    sram_dq_in
);

    state_t               state_reg;
    logic [WORD_AW-1:0]   word_reg;
    logic [SRAM_DW-1:0]   wdata_hi_reg;
    logic [31:0]          rdata_reg;
    logic [SRAM_AW-1:0]   sram_addr_reg;
    logic                 sram_we_n_reg;
    logic [SRAM_DW-1:0]   sram_dq_out_reg;
    logic                 sram_dq_oe_reg;

    logic [31:0]          offset_addr;
    logic [WORD_AW-1:0]   req_word;
    logic                 unused_addr_bits;
    logic                 read_hit;
    logic                 wait_start;
    logic                 wait_last;
    logic                 ready_comb;

    // Word index of the incoming request; byte-lane bits and bits above the
    // SRAM range are deliberately discarded.
    assign offset_addr      = bus.addr - 32'(ADDR_OFFSET);
    assign req_word         = offset_addr[18:2];
    assign unused_addr_bits = ^{offset_addr[31:19], offset_addr[1:0]};

`ifdef SRAM_READ_HIT_EN
    logic               hit_valid_reg;
    logic [WORD_AW-1:0] hit_word_reg;

    assign read_hit = hit_valid_reg && (hit_word_reg == req_word);

    // rdata already holds the buffered word, so a hit needs no SRAM traffic.
    // A store to the buffered word is caught as it leaves IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_valid_reg <= 1'b0;
            hit_word_reg  <= '0;
        end else if (state_reg == ST_RD_HI && wait_last) begin
            hit_valid_reg <= 1'b1;
            hit_word_reg  <= word_reg;
        end else if (state_reg == ST_IDLE && bus.mem_w_en && req_word == hit_word_reg) begin
            hit_valid_reg <= 1'b0;
        end
    end
`else
    assign read_hit = 1'b0;
`endif

    // Load the wait counter when an access state is about to be entered:
    // leaving IDLE, or moving from a low-half state to its high-half state.
    assign wait_start =
        (state_reg == ST_IDLE && (bus.mem_w_en || (bus.mem_r_en && !read_hit))) ||
        ((state_reg == ST_RD_LO || state_reg == ST_WR_LO) && wait_last);

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .start (wait_start),
        .last  (wait_last)
    );

    // Bus outputs are registered, so each one is set on the edge that enters
    // the state in which it must be valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            word_reg        <= '0;
            wdata_hi_reg    <= '0;
            rdata_reg       <= '0;
            sram_addr_reg   <= '0;
            sram_we_n_reg   <= 1'b1;
            sram_dq_out_reg <= '0;
            sram_dq_oe_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.mem_w_en) begin
                        // Write wins over a simultaneous read.
                        state_reg       <= ST_WR_LO;
                        word_reg        <= req_word;
                        wdata_hi_reg    <= bus.wdata[31:16];
                        sram_addr_reg   <= halfword_addr(req_word, 1'b0);
                        sram_dq_out_reg <= bus.wdata[15:0];
                        sram_we_n_reg   <= 1'b0;
                        sram_dq_oe_reg  <= 1'b1;
                    end else if (bus.mem_r_en && !read_hit) begin
                        state_reg     <= ST_RD_LO;
                        word_reg      <= req_word;
                        sram_addr_reg <= halfword_addr(req_word, 1'b0);
                    end
                end
                ST_RD_LO: begin
                    if (wait_last) begin
                        state_reg       <= ST_RD_HI;
                        rdata_reg[15:0] <= sram_dq_in;
                        sram_addr_reg   <= halfword_addr(word_reg, 1'b1);
                    end
                end
                ST_RD_HI: begin
                    if (wait_last) begin
                        state_reg        <= ST_DONE;
                        rdata_reg[31:16] <= sram_dq_in;
                    end
                end
                ST_WR_LO: begin
                    if (wait_last) begin
                        state_reg       <= ST_WR_HI;
                        sram_addr_reg   <= halfword_addr(word_reg, 1'b1);
                        sram_dq_out_reg <= wdata_hi_reg;
                    end
                end
                ST_WR_HI: begin
                    if (wait_last) begin
                        state_reg      <= ST_DONE;
                        sram_we_n_reg  <= 1'b1;
                        sram_dq_oe_reg <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // ready must respond in the same cycle a request appears in IDLE.
    assign ready_comb = (state_reg == ST_DONE) ||
                        (state_reg == ST_IDLE && !bus.mem_w_en && (!bus.mem_r_en || read_hit));

    assign bus.ready    = ready_comb;
    assign bus.freeze   = ~ready_comb;
    assign bus.rdata    = rdata_reg;
    assign sram_addr    = sram_addr_reg;
    assign sram_we_n    = sram_we_n_reg;
    assign sram_dq_out  = sram_dq_out_reg;
    assign sram_dq_oe   = sram_dq_oe_reg;

endmodule

// File: tb/tb_sram_mem_controller.sv
`timescale 1ns/1ps
module tb_sram_mem_controller;
    import sram_ctrl_pkg::*;

    localparam int WC   = 3;
    localparam int AOFF = 1024;
`ifdef SRAM_READ_HIT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [SRAM_AW-1:0] sram_addr;
    logic               sram_we_n;
    logic [SRAM_DW-1:0] sram_dq_out;
    logic               sram_dq_oe;
    logic [SRAM_DW-1:0] sram_dq_in;

    sram_mem_controller_if bus ();

    sram_mem_controller #(
        .WAIT_CYCLES (WC),
        .ADDR_OFFSET (AOFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .sram_addr   (sram_addr),
        .sram_we_n   (sram_we_n),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_hw(input int i);
        return 16'(i * 40503) ^ 16'h5A5A;
    endfunction

    // External SRAM: 64 halfwords, written on any edge with the strobe low.
    logic [15:0] sram_arr [0:63];
    logic        sram_loaded = 1'b0;
    assign sram_dq_in = sram_arr[sram_addr[5:0]];
    always @(posedge clk) begin
        if (!sram_loaded) begin
            for (int i = 0; i < 64; i++) sram_arr[i] <= init_hw(i);
            sram_loaded <= 1'b1;
        end else if (!sram_we_n) begin
            sram_arr[sram_addr[5:0]] <= sram_dq_out;
        end
    end

    // Expected per-cycle outputs, produced by the transaction model.
    typedef struct packed {
        logic        rdy;
        logic        we_n;
        logic        oe;
        logic [17:0] addr;
        logic        dq_chk;
        logic [15:0] dq;
        logic        rd_chk;
        logic [31:0] rd;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int we_low_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!sram_we_n) we_low_cnt++;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ready",     32'(bus.ready),  32'(e.rdy));
            chk("freeze",    32'(bus.freeze), 32'(!e.rdy));
            chk("sram_we_n", 32'(sram_we_n),  32'(e.we_n));
            chk("sram_dq_oe", 32'(sram_dq_oe), 32'(e.oe));
            chk("sram_addr", 32'(sram_addr),  32'(e.addr));
            if (e.dq_chk) chk("sram_dq_out", 32'(sram_dq_out), 32'(e.dq));
            if (e.rd_chk) chk("rdata", bus.rdata, e.rd);
        end
    end

    // Transaction-level model state.
    logic [31:0] model_words [0:31];
    logic [31:0] model_rdata;
    logic [17:0] last_addr;
    bit          hit_valid;
    logic [16:0] hit_w;

    function automatic logic [16:0] w_of(input logic [31:0] a);
        return 17'((a - 32'(AOFF)) >> 2);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 idle, 1 load, 2 store, 3 load+store. rst_at >= 1 asserts reset
    // during that access cycle. ncyc = cycles consumed including DONE.
    task automatic do_op(input int kind, input logic [31:0] a, input logic [31:0] data,
                         input int rst_at, output int ncyc);
        logic [16:0] w;
        exp_t        e;
        bit          wr;
        bit          rd;
        w  = w_of(a);
        wr = (kind == 2 || kind == 3);
        rd = (kind == 1 || kind == 3);
        step();
        bus.mem_r_en = rd;
        bus.mem_w_en = wr;
        bus.addr     = a;
        bus.wdata    = data;
        e = '0;
        e.we_n = 1'b1;
        e.addr = last_addr;
        if (!wr && (!rd || (HIT_EN && hit_valid && hit_w == w))) begin
            e.rdy    = 1'b1;
            e.rd_chk = 1'b1;
            e.rd     = rd ? model_words[w[4:0]] : model_rdata;
            exp_q.push_back(e);
            $display("op idle/hit kind=%0d addr=%h rdata_exp=%h", kind, a, e.rd);
            ncyc = 1;
            return;
        end
        exp_q.push_back(e);
        for (int c = 1; c <= 2 * WC; c++) begin
            step();
            bus.addr     = $urandom;
            bus.wdata    = $urandom;
            bus.mem_r_en = 1'($urandom);
            bus.mem_w_en = 1'($urandom);
            if (c == rst_at) rst = 1'b1;
            e = '0;
            e.addr   = {w, 1'(c > WC)};
            e.we_n   = !wr;
            e.oe     = wr;
            e.dq_chk = wr;
            e.dq     = (c > WC) ? data[31:16] : data[15:0];
            exp_q.push_back(e);
            if (c == rst_at) begin
                step();
                rst          = 1'b0;
                bus.mem_r_en = 1'b0;
                bus.mem_w_en = 1'b0;
                model_rdata  = '0;
                last_addr    = '0;
                hit_valid    = 1'b0;
                e = '0;
                e.rdy    = 1'b1;
                e.we_n   = 1'b1;
                e.dq_chk = 1'b1;
                e.rd_chk = 1'b1;
                exp_q.push_back(e);
                $display("op aborted by reset kind=%0d addr=%h cycle=%0d", kind, a, c);
                ncyc = c + 2;
                return;
            end
        end
        last_addr = {w, 1'b1};
        if (wr) begin
            model_words[w[4:0]] = data;
            if (hit_w == w) hit_valid = 1'b0;
        end else begin
            model_rdata = model_words[w[4:0]];
            hit_valid   = 1'b1;
            hit_w       = w;
        end
        step();
        bus.mem_r_en = 1'($urandom);
        bus.mem_w_en = 1'($urandom);
        bus.addr     = $urandom;
        e = '0;
        e.rdy    = 1'b1;
        e.we_n   = 1'b1;
        e.addr   = last_addr;
        e.rd_chk = 1'b1;
        e.rd     = model_rdata;
        exp_q.push_back(e);
        $display("op kind=%0d addr=%h wdata=%h rdata_exp=%h", kind, a, data, model_rdata);
        ncyc = 2 * WC + 2;
    endtask

    initial begin
        exp_t        e;
        int          n;
        int          snap;
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;
        rst          = 1'b1;
        for (int i = 0; i < 32; i++) model_words[i] = {init_hw(2 * i + 1), init_hw(2 * i)};
        model_rdata = '0;
        last_addr   = '0;
        hit_valid   = 1'b0;
        hit_w       = '0;
        repeat (3) step();
        rst = 1'b0;
        e = '0;
        e.rdy    = 1'b1;
        e.we_n   = 1'b1;
        e.dq_chk = 1'b1;
        e.rd_chk = 1'b1;
        exp_q.push_back(e);

        chk("model_w_of_1032", 32'(w_of(32'd1032)), 32'd2);

        // Store 0xDEADBEEF at 1032 -> halfwords 4 and 5.
        snap = we_low_cnt;
        do_op(2, 32'd1032, 32'hDEADBEEF, -1, n);
        chk("store_cycles", n, 8);
        @(negedge clk);
        #1;
        chk("store_we_n_low_cycles", we_low_cnt - snap, 6);

        // Load it back, then repeat the load (hit when the buffer exists).
        do_op(1, 32'd1032, 32'h0, -1, n);
        @(negedge clk);
        #1;
        chk("load_rdata", bus.rdata, 32'hDEADBEEF);
        do_op(1, 32'd1032, 32'h0, -1, n);
        chk("reload_cycles", n, HIT_EN ? 1 : 8);

        // Back-to-back store then load of the same word.
        do_op(2, 32'd1032, 32'h12345678, -1, n);
        do_op(1, 32'd1032, 32'h0, -1, n);
        chk("load_after_store_cycles", n, 8);
        @(negedge clk);
        #1;
        chk("load2_rdata", bus.rdata, 32'h12345678);

        // Both enables: write only, rdata untouched.
        do_op(3, 32'd1040, 32'hCAFEF00D, -1, n);
        @(negedge clk);
        #1;
        chk("both_en_rdata_kept", bus.rdata, 32'h12345678);
        do_op(1, 32'd1040, 32'h0, -1, n);
        @(negedge clk);
        #1;
        chk("both_en_written", bus.rdata, 32'hCAFEF00D);

        // Reset during the first WR_HI cycle of a store to word 31.
        do_op(2, 32'd1148, 32'hA5A5C3C3, WC + 1, n);
        @(negedge clk);
        #1;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);

        // Randomized traffic on words 0..15.
        for (int i = 0; i < 300; i++) begin
            int          k;
            int          kind;
            int          wi;
            logic [31:0] a;
            k    = $urandom_range(0, 9);
            kind = (k < 2) ? 0 : (k < 6) ? 1 : (k < 9) ? 2 : 3;
            wi   = (kind == 1 && $urandom_range(0, 2) == 0) ? int'(hit_w) : $urandom_range(0, 15);
            a    = 32'(AOFF) + {13'($urandom), 17'(wi), 2'($urandom)};
            do_op(kind, a, $urandom, -1, n);
        end

        do_op(0, 32'd0, 32'd0, -1, n);
        do_op(0, 32'd0, 32'd0, -1, n);
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
